// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word per PC, holds it
// for decode, and redirects by dropping whatever response is still in flight.
module fetch_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_resp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [XLEN-1:0]  instruction,
  output logic [XLEN-1:0]  instr_pc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  state_t           state;
  state_t           state_next;
  logic [XLEN-1:0]  pc;
  logic             kill;

  logic             redirect_take;
  logic             capture;
  logic             deliver;
  logic [XLEN-1:0]  redirect_aligned;

  // A redirect in IDLE is meaningless (nothing fetched yet) and is ignored.
  always_comb begin
    redirect_take = redirect_valid && (state != IDLE);
    capture       = (state == WAIT) && mem_resp_valid && !kill && !redirect_valid;
    deliver       = (state == HOLD) && instr_ready && !redirect_valid;
  end

  assign redirect_aligned = redirect_pc & ALIGN_MASK;
  assign mem_addr         = pc;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_next = (kill || redirect_valid) ? REQ : HOLD;
      end
      HOLD: begin
        if (redirect_valid || instr_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    instr_valid   = 1'b0;
    unique case (state)
      REQ:     mem_req_valid = 1'b1;
      HOLD:    instr_valid   = 1'b1;
      default: ;
    endcase
  end

  // kill marks the single outstanding request whose response must be dropped;
  // a second redirect only moves pc, the flag is already set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_VECTOR;
      kill <= 1'b0;
    end else begin
      if (redirect_take) begin
        pc <= redirect_aligned;
      end else if (capture) begin
        pc <= pc + PC_STEP;
      end

      unique case (state)
        REQ:  kill <= redirect_take && mem_req_ready;
        WAIT: begin
          if (mem_resp_valid)     kill <= 1'b0;
          else if (redirect_take) kill <= 1'b1;
        end
        default: kill <= 1'b0;
      endcase
    end
  end

  // NOTE: the held instruction is ordinary datapath flops, reset to zero so
  // decode never sees X after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction <= '0;
      instr_pc    <= '0;
    end else if (capture) begin
      instruction <= mem_resp_data;
      instr_pc    <= pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (deliver) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  // Protocol invariants: one request at a time, held word stable until consumed.
  a_req_hold_exclusive : assert property (
    @(posedge clock) disable iff (!reset) !(mem_req_valid && instr_valid));

  a_hold_stable : assert property (
    @(posedge clock) disable iff (!reset)
      (instr_valid && !instr_ready && !redirect_valid)
        |=> (instr_valid && $stable(instruction) && $stable(instr_pc)));

  a_no_req_in_wait : assert property (
    @(posedge clock) disable iff (!reset)
      (state == WAIT) |-> !mem_req_valid);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_W2  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              mem_req_ready = 1'b0;
  logic              mem_resp_valid = 1'b0;
  logic [XLEN-1:0]   mem_resp_data;
  logic              redirect_valid = 1'b0;
  logic [XLEN-1:0]   redirect_pc = '0;
  logic              instr_ready = 1'b0;

  logic              mem_req_valid;
  logic [XLEN-1:0]   mem_addr;
  logic              instr_valid;
  logic [XLEN-1:0]   instruction;
  logic [XLEN-1:0]   instr_pc;
  logic [CNT_W-1:0]  fetch_count;

  logic              w_mem_req_valid;
  logic [XLEN-1:0]   w_mem_addr;
  logic              w_instr_valid;
  logic [XLEN-1:0]   w_instruction;
  logic [XLEN-1:0]   w_instr_pc;
  logic [CNT_W2-1:0] w_fetch_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory returns the word at the address currently presented.
  assign mem_resp_data = mem_fn(mem_addr);

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .INSTR_BYTES(4), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .fetch_count(fetch_count)
  );

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(32'hFFFF_FFFC), .INSTR_BYTES(4), .CNT_W(CNT_W2)) u_dut_wrap (
    .clock(clock), .reset(reset),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(w_mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready),
    .instruction(w_instruction), .instr_pc(w_instr_pc), .fetch_count(w_fetch_count)
  );

  task automatic do_reset();
    reset          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_instr_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (instr_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, instr_valid, instruction, instr_pc, fetch_count, mem_addr, w_mem_addr} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 32'h0, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL reset_values: got req=%b iv=%b ins=%h ipc=%h cnt=%h addr=%h waddr=%h",
               mem_req_valid, instr_valid, instruction, instr_pc, fetch_count, mem_addr, w_mem_addr);
    end
    do_reset();
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: mem_req_valid=%b expected 0", mem_req_valid);
    end
    @(negedge clock);
    checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", mem_req_valid, mem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] addrs[$];
    logic [XLEN-1:0] pcs[$];
    int deliv_cyc[$];
    int first_req = -1;
    int first_valid = -1;
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; instr_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && pcs.size() < 3; cyc++) begin
      @(negedge clock);
      if (mem_req_valid && first_req < 0) first_req = cyc;
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (mem_req_valid && mem_req_ready) addrs.push_back(mem_addr);
      if (instr_valid && instr_ready) begin
        pcs.push_back(instr_pc);
        deliv_cyc.push_back(cyc);
      end
    end
    @(negedge clock);
    instr_ready = 1'b0;
    checks++;
    if (pcs.size() != 3 || addrs.size() < 3) begin
      errors++;
      $display("FAIL seq_timeout: deliveries=%0d requests=%0d expected 3", pcs.size(), addrs.size());
    end else begin
      checks++;
      if ({addrs[0], addrs[1], addrs[2]} !== {32'h0, 32'h4, 32'h8}) begin
        errors++;
        $display("FAIL seq_mem_addr: got %h %h %h expected 0 4 8", addrs[0], addrs[1], addrs[2]);
      end
      checks++;
      if ({pcs[0], pcs[1], pcs[2]} !== {32'h0, 32'h4, 32'h8}) begin
        errors++;
        $display("FAIL seq_instr_pc: got %h %h %h expected 0 4 8", pcs[0], pcs[1], pcs[2]);
      end
      checks++;
      if ((first_valid - first_req) != 2 || (deliv_cyc[1] - deliv_cyc[0]) != 3 ||
          (deliv_cyc[2] - deliv_cyc[1]) != 3) begin
        errors++;
        $display("FAIL seq_latency: latency=%0d gaps=%0d,%0d expected 2 and 3,3",
                 first_valid - first_req, deliv_cyc[1] - deliv_cyc[0], deliv_cyc[2] - deliv_cyc[1]);
      end
    end
    checks++;
    if (fetch_count !== 16'd3) begin
      errors++;
      $display("FAIL seq_count: fetch_count=%0d expected 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; instr_ready = 1'b0;
    wait_instr_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: instr_valid never rose");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({instr_valid, instruction, instr_pc, mem_req_valid, fetch_count} !==
          {1'b1, mem_fn(32'h0), 32'h0, 1'b0, 16'h0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: iv=%b ins=%h ipc=%h req=%b cnt=%0d expected iv=1 ins=%h ipc=0 req=0 cnt=0",
                 i, instr_valid, instruction, instr_pc, mem_req_valid, fetch_count, mem_fn(32'h0));
      end
    end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    checks++;
    if ({fetch_count, instr_valid, mem_req_valid, mem_addr} !== {16'd1, 1'b0, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL stall_release: cnt=%0d iv=%b req=%b addr=%h expected cnt=1 iv=0 req=1 addr=4",
               fetch_count, instr_valid, mem_req_valid, mem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clock);
    redirect_valid = 1'b0; mem_resp_valid = 1'b1;
    checks++;
    if ({mem_req_valid, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rwait_pending: req=%b iv=%b expected 0 0", mem_req_valid, instr_valid);
    end
    @(negedge clock);
    checks++;
    if ({mem_req_valid, mem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL rwait_discard: req=%b addr=%h iv=%b expected req=1 addr=00000100 iv=0",
               mem_req_valid, mem_addr, instr_valid);
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({instr_valid, instr_pc, instruction, fetch_count} !== {1'b1, 32'h100, mem_fn(32'h100), 16'h0}) begin
      errors++;
      $display("FAIL rwait_refetch: iv=%b ipc=%h ins=%h cnt=%0d expected iv=1 ipc=00000100 ins=%h cnt=0",
               instr_valid, instr_pc, instruction, fetch_count, mem_fn(32'h100));
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; instr_ready = 1'b0;
    wait_instr_valid(20, ok);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h242;
    @(negedge clock);
    instr_ready = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (!ok || {fetch_count, instr_valid, mem_req_valid, mem_addr} !== {16'h0, 1'b0, 1'b1, 32'h240}) begin
      errors++;
      $display("FAIL rhold: reached=%b cnt=%0d iv=%b req=%b addr=%h expected cnt=0 iv=0 req=1 addr=00000240",
               ok, fetch_count, instr_valid, mem_req_valid, mem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    logic [XLEN-1:0] pcs[$];
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; instr_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && pcs.size() < 2; cyc++) begin
      @(negedge clock);
      if (w_instr_valid && instr_ready) pcs.push_back(w_instr_pc);
    end
    checks++;
    if (pcs.size() != 2) begin
      errors++;
      $display("FAIL pc_wrap_timeout: deliveries=%0d expected 2", pcs.size());
    end else if ({pcs[0], pcs[1]} !== {32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL pc_wrap: got %h %h expected fffffffc 00000000", pcs[0], pcs[1]);
    end
  endtask

  task automatic test_count_wrap();
    int delivered = 0;
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; instr_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && delivered < 17; cyc++) begin
      @(negedge clock);
      if (w_instr_valid) delivered++;
    end
    @(negedge clock);
    instr_ready = 1'b0;
    checks++;
    if (delivered != 17 || w_fetch_count !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap: delivered=%0d fetch_count=%0d expected 17 deliveries count 1",
               delivered, w_fetch_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok = 1'b0;
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      if (fetch_count == 16'd1) ok = 1'b1;
    end
    mem_resp_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (!ok || {mem_req_valid, instr_valid, fetch_count} !== {1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL midwait_setup: reached=%b req=%b iv=%b cnt=%0d expected WAIT with cnt=1",
               ok, mem_req_valid, instr_valid, fetch_count);
    end
    #2 reset = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, instr_valid, instruction, instr_pc, fetch_count, mem_addr} !== '0) begin
      errors++;
      $display("FAIL midwait_async: req=%b iv=%b ins=%h ipc=%h cnt=%0d addr=%h expected all zero",
               mem_req_valid, instr_valid, instruction, instr_pc, fetch_count, mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_req_ready = ~mem_req_ready;
      checks++;
      if ({mem_req_valid, instr_valid, fetch_count, mem_addr} !== '0) begin
        errors++;
        $display("FAIL midwait_held[%0d]: req=%b iv=%b cnt=%0d addr=%h expected all zero",
                 i, mem_req_valid, instr_valid, fetch_count, mem_addr);
      end
    end
    reset = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midwait_idle: req=%b expected 0", mem_req_valid);
    end
    @(negedge clock);
    checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL midwait_restart: req=%b addr=%h expected req=1 addr=00000000", mem_req_valid, mem_addr);
    end
  endtask

  // Transaction-level model: next fetch address, one outstanding request with a
  // drop flag, the held word, and the delivery count.
  task automatic test_random();
    bit              outstanding = 1'b0;
    bit              killed = 1'b0;
    bit              holding = 1'b0;
    bit              req_now;
    bit              old_out;
    bit              old_hold;
    logic [XLEN-1:0] exp_addr = 32'h0;
    logic [XLEN-1:0] req_addr = 32'h0;
    logic [XLEN-1:0] hold_addr = 32'h0;
    logic [CNT_W-1:0] exp_count = '0;
    do_reset();
    @(negedge clock);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      req_now = !outstanding && !holding;
      checks++;
      if ({mem_req_valid, instr_valid} !== {req_now, holding}) begin
        errors++;
        $display("FAIL rand_handshake @%0d: req=%b iv=%b expected req=%b iv=%b",
                 cyc, mem_req_valid, instr_valid, req_now, holding);
      end
      if (req_now) begin
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL rand_addr @%0d: addr=%h expected %h", cyc, mem_addr, exp_addr);
        end
      end
      if (holding) begin
        checks++;
        if ({instr_pc, instruction} !== {hold_addr, mem_fn(hold_addr)}) begin
          errors++;
          $display("FAIL rand_instr @%0d: ipc=%h ins=%h expected ipc=%h ins=%h",
                   cyc, instr_pc, instruction, hold_addr, mem_fn(hold_addr));
        end
      end
      checks++;
      if (fetch_count !== exp_count) begin
        errors++;
        $display("FAIL rand_count @%0d: cnt=%0d expected %0d", cyc, fetch_count, exp_count);
      end

      mem_req_ready  = ($urandom_range(0, 99) < 60);
      mem_resp_valid = outstanding && ($urandom_range(0, 99) < 50);
      instr_ready    = ($urandom_range(0, 1) == 1);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = $urandom;

      old_out  = outstanding;
      old_hold = holding;
      if (req_now && mem_req_ready) begin
        outstanding = 1'b1;
        killed      = redirect_valid;
        req_addr    = exp_addr;
      end
      if (old_out) begin
        if (mem_resp_valid) begin
          outstanding = 1'b0;
          if (!killed && !redirect_valid) begin
            holding   = 1'b1;
            hold_addr = req_addr;
            exp_addr  = req_addr + 32'd4;
          end
        end else if (redirect_valid) begin
          killed = 1'b1;
        end
      end
      if (old_hold && (instr_ready || redirect_valid)) begin
        holding = 1'b0;
        if (!redirect_valid) exp_count = exp_count + 1'b1;
      end
      if (redirect_valid) exp_addr = {redirect_pc[XLEN-1:2], 2'b00};
      @(negedge clock);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_pc_wrap();
    test_count_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC, address and instruction width.
REQ-002 Parameter RESET_VECTOR, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter INSTR_BYTES, default 4, power of two, SHALL set the sequential PC increment and the redirect alignment.
REQ-004 Parameter CNT_W, default 16, SHALL set the width of fetch_count.
REQ-005 Port list SHALL be:
  clock           in   1     sole clock, rising edge
  reset           in   1     asynchronous, active-low
  mem_req_valid   out  1     fetch request valid
  mem_req_ready   in   1     memory accepts request
  mem_addr        out  XLEN  fetch address (current PC)
  mem_resp_valid  in   1     response data valid
  mem_resp_data   in   XLEN  fetched instruction word
  redirect_valid  in   1     branch/jump redirect, single-cycle pulse
  redirect_pc     in   XLEN  redirect target
  instr_valid     out  1     instruction available to decode
  instr_ready     in   1     decode consumes instruction
  instruction     out  XLEN  held instruction
  instr_pc        out  XLEN  PC of held instruction
  fetch_count     out  CNT_W instructions delivered
REQ-006 The single clock is clock; reset is asynchronous and active-low.

Function
REQ-007 FSM states SHALL be IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-008 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-009 REQ: mem_req_valid=1, mem_addr=pc; on mem_req_ready=1 go to WAIT.
REQ-010 WAIT: mem_req_valid=0; on mem_resp_valid=1 capture instruction<=mem_resp_data, instr_pc<=pc, pc<=pc+INSTR_BYTES, go to HOLD.
REQ-011 HOLD: instr_valid=1, instruction/instr_pc stable; on instr_ready=1 increment fetch_count and go to REQ in the next cycle.
REQ-012 Minimum latency from REQ entry to instr_valid SHALL be 2 cycles (ready and response each in first possible cycle); throughput at most one instruction per 3 cycles.
REQ-013 PC increment SHALL wrap modulo 2^XLEN (all-ones minus INSTR_BYTES-1 plus INSTR_BYTES -> 0).
REQ-014 Redirect target SHALL be aligned by forcing the low log2(INSTR_BYTES) bits to 0.
REQ-015 Redirect in REQ or HOLD: pc<=aligned redirect_pc, instr_valid=0 next cycle, fetch_count unchanged, state REQ.
REQ-016 Redirect in HOLD coincident with instr_ready: redirect wins; instruction not counted as delivered.
REQ-017 Redirect in REQ coincident with mem_req_ready: the accepted request is treated as a WAIT with kill set.
REQ-018 Redirect in WAIT: set kill flag, pc<=aligned redirect_pc; the pending response SHALL be discarded (no HOLD, no pc increment), then go to REQ and clear kill.
REQ-019 Redirect in WAIT coincident with mem_resp_valid: response discarded, go to REQ with new pc.
REQ-020 A second redirect before a killed response returns SHALL overwrite pc; only one response is discarded.
REQ-021 fetch_count SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-022 reset=0 at any time, including mid-WAIT, SHALL immediately force: state IDLE, pc=RESET_VECTOR, mem_req_valid=0, instr_valid=0, instruction=0, instr_pc=0, fetch_count=0, kill=0.
REQ-023 A memory response arriving after reset release for a request issued before reset SHALL NOT be possible (system contract); no tracking required.

Verification
REQ-024 Reset release, memory always ready, 1-cycle response, instr_ready=1 -> mem_addr 0,4,8; instr_pc 0,4,8; fetch_count 3 after third delivery.
REQ-025 instr_ready=0 for 5 cycles in HOLD -> instruction/instr_pc stable, no new mem_req_valid, fetch_count unchanged.
REQ-026 Redirect to 0x103 during WAIT -> response discarded, next mem_addr 0x100, next instr_pc 0x100.
REQ-027 Redirect and instr_ready same HOLD cycle -> fetch_count unchanged, next mem_addr = redirect target.
REQ-028 RESET_VECTOR=0xFFFFFFFC -> instr_pc 0xFFFFFFFC then 0x00000000.
REQ-029 reset asserted mid-WAIT with mem_req_ready toggling -> all outputs at reset values asynchronously; fetch restarts at RESET_VECTOR after one IDLE cycle.
